// File: rtl/decode_queued_pkg.sv
// ============================================================================
// decode_queued_pkg
//   RV32I base opcodes, the canonical NOP and the immediate-format
//   classifier shared by the queued decode stage, decode-2 and the bench.
// Revision: 1.0
// ============================================================================
`default_nettype none

package decode_queued_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // addi x0, x0, 0 -- what the stage presents while the queue is empty
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } imm_fmt_e;

  // Map a 7-bit opcode to its immediate format; anything outside RV32I is FMT_BAD
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] opc);
    imm_fmt_e fmt;
    case (opc)
      OPC_OP:                                           fmt = FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                         fmt = FMT_I;
      OPC_STORE:                                        fmt = FMT_S;
      OPC_BRANCH:                                       fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                               fmt = FMT_U;
      OPC_JAL:                                          fmt = FMT_J;
      default:                                          fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_queued_inst_fifo.sv
// ============================================================================
// inst_fifo
//   DEPTH-entry FIFO for {pc, instruction} pairs. Pointers carry one extra
//   wrap bit so full and empty are told apart without a separate counter.
//   Storage is left unreset; only the pointers are cleared.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Next pointer values: flush wins, otherwise advance on push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/decode_queued.sv
// ============================================================================
// decode_queued
//   Queued RV32I decode stage between fetch and decode-2. Buffers fetched
//   instructions, presents the head entry as decoded fields and flags
//   non-RV32I opcodes. An empty queue presents PC 0 and a NOP.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_queued
  import decode_queued_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int XLEN         = 32,
  parameter int IMM_SIGN_EXT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FLUSH,
  input  logic                     STALL,
  input  logic                     INST_VALID,
  output logic                     INST_READY,
  input  logic [XLEN-1:0]          INST_PC,
  input  logic [31:0]              INST_DATA,
  output logic                     DECODE_VALID,
  output logic [XLEN-1:0]          DECODE_PC,
  output logic [6:0]               DECODE_OPCODE,
  output logic [4:0]               DECODE_RD,
  output logic [4:0]               DECODE_RS1,
  output logic [4:0]               DECODE_RS2,
  output logic [2:0]               DECODE_FUNCT3,
  output logic [6:0]               DECODE_FUNCT7,
  output logic [XLEN-1:0]          DECODE_IMM,
  output logic                     DECODE_ILLEGAL,
  output logic [$clog2(DEPTH):0]   QUEUE_LEVEL
);

  localparam int WIDTH = XLEN + 32;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic [31:0]      w_inst;
  imm_fmt_e         w_fmt;
  logic [31:0]      w_imm_z;
  logic [31:0]      w_imm_s;

  // Ready comes straight from the registered full flag, never from STALL
  assign INST_READY   = ~w_full;
  assign DECODE_VALID = ~w_empty;
  assign w_push       = INST_VALID & ~w_full & ~FLUSH;
  assign w_pop        = ~w_empty & ~STALL & ~FLUSH;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .flush_i (FLUSH),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i ({INST_PC, INST_DATA}),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (QUEUE_LEVEL)
  );

  // Substitute PC 0 / NOP for the stale storage word while empty
  always_comb begin
    w_inst    = INST_NOP;
    DECODE_PC = '0;
    if (!w_empty) begin
      w_inst    = w_head[31:0];
      DECODE_PC = w_head[WIDTH-1:32];
    end
  end

  assign DECODE_OPCODE = w_inst[6:0];
  assign DECODE_RD     = w_inst[11:7];
  assign DECODE_RS1    = w_inst[19:15];
  assign DECODE_RS2    = w_inst[24:20];
  assign DECODE_FUNCT3 = w_inst[14:12];
  assign DECODE_FUNCT7 = w_inst[31:25];

  // Assemble the immediate field both zero- and sign-extended to 32 bits
  always_comb begin
    w_fmt   = opcode_fmt(w_inst[6:0]);
    w_imm_z = '0;
    w_imm_s = '0;
    case (w_fmt)
      FMT_I: begin
        w_imm_z = {20'b0, w_inst[31:20]};
        w_imm_s = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      FMT_S: begin
        w_imm_z = {20'b0, w_inst[31:25], w_inst[11:7]};
        w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      FMT_B: begin
        w_imm_z = {19'b0, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
        w_imm_s = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                   w_inst[11:8], 1'b0};
      end
      FMT_U: begin
        w_imm_z = {w_inst[31:12], 12'b0};
        w_imm_s = {w_inst[31:12], 12'b0};
      end
      FMT_J: begin
        w_imm_z = {11'b0, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
        w_imm_s = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                   w_inst[30:21], 1'b0};
      end
      default: begin
        w_imm_z = '0;
        w_imm_s = '0;
      end
    endcase
  end

  // Pick the extension mode; unknown opcodes give 0 (sign) or all ones (legacy)
  always_comb begin
    DECODE_ILLEGAL = (w_fmt == FMT_BAD) || (w_inst[1:0] != 2'b11);
    if (IMM_SIGN_EXT != 0) begin
      DECODE_IMM = (w_fmt == FMT_BAD) ? '0 : XLEN'($signed(w_imm_s));
    end else begin
      DECODE_IMM = (w_fmt == FMT_BAD) ? '1 : XLEN'(w_imm_z);
    end
  end

endmodule

`default_nettype wire
